// File: rtl/sp_wb8_responder.sv
// Bridges an 8-bit Wishbone slave port onto a 32-bit Wishbone master port,
// with a one-word read buffer (write-through, invalidatable).
module sp_wb8_responder #(
  parameter logic [0:7]  BASE_ADR = 8'h00,
  parameter int unsigned CACHE_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:23] s_adr_i,
  input  logic [0:7]  s_dat_i,
  output logic [0:7]  s_dat_o,
  input  logic        s_we_i,
  input  logic [0:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [0:31] m_adr_o,
  output logic [0:31] m_dat_o,
  input  logic [0:31] m_dat_i,
  output logic        m_we_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic [0:3]  m_sel_o,
  input  logic        m_ack_i,
  input  logic        inv_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t      state;
  logic        valid;
  logic [0:21] rbuf_tag;
  logic [0:31] rbuf_data;

  // Request captured in IDLE so the 32-bit cycle is immune to s_adr_i/s_dat_i changes.
  logic [0:21] req_word;
  logic [0:1]  req_lane;
  logic [0:7]  req_dat;
  logic        inv_seen;
  logic        abort;

  logic req;
  logic hit;

  function automatic logic [0:7] lane_of(input logic [0:31] w, input logic [0:1] l);
    logic [0:7] r;
    case (l)
      2'd0:    r = w[0:7];
      2'd1:    r = w[8:15];
      2'd2:    r = w[16:23];
      default: r = w[24:31];
    endcase
    return r;
  endfunction

  function automatic logic [0:31] merge_lane(input logic [0:31] w, input logic [0:1] l,
                                             input logic [0:7] b);
    logic [0:31] r;
    r = w;
    case (l)
      2'd0:    r[0:7]   = b;
      2'd1:    r[8:15]  = b;
      2'd2:    r[16:23] = b;
      default: r[24:31] = b;
    endcase
    return r;
  endfunction

  function automatic logic [0:3] lane_sel(input logic [0:1] l);
    logic [0:3] r;
    case (l)
      2'd0:    r = 4'b1000;
      2'd1:    r = 4'b0100;
      2'd2:    r = 4'b0010;
      default: r = 4'b0001;
    endcase
    return r;
  endfunction

  always_comb begin
    req = s_cyc_i & s_stb_i;
    // A same-edge invalidate wins over a hit.
    hit = (CACHE_EN != 0) && valid && !inv_i && (rbuf_tag == s_adr_i[0:21]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      valid    <= 1'b0;
      s_ack_o  <= 1'b0;
      s_dat_o  <= '0;
      m_cyc_o  <= 1'b0;
      m_stb_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_sel_o  <= '0;
      m_dat_o  <= '0;
      m_adr_o  <= '0;
      inv_seen <= 1'b0;
      abort    <= 1'b0;
    end else begin
      if (inv_i) valid <= 1'b0;
      case (state)
        IDLE: begin
          s_ack_o <= 1'b0;
          if (req) begin
            req_word <= s_adr_i[0:21];
            req_lane <= s_adr_i[22:23];
            req_dat  <= s_dat_i;
            m_adr_o  <= {BASE_ADR, s_adr_i[0:21], 2'b00};
            inv_seen <= 1'b0;
            abort    <= 1'b0;
            if (!s_we_i) begin
              if (hit) begin
                s_dat_o <= lane_of(rbuf_data, s_adr_i[22:23]);
                s_ack_o <= 1'b1;
                state   <= ACK;
              end else begin
                m_cyc_o <= 1'b1;
                m_stb_o <= 1'b1;
                m_we_o  <= 1'b0;
                m_sel_o <= 4'b1111;
                m_dat_o <= '0;
                state   <= RD;
              end
            end else if (s_sel_i[0]) begin
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_we_o  <= 1'b1;
              m_sel_o <= lane_sel(s_adr_i[22:23]);
              m_dat_o <= {4{s_dat_i}};
              state   <= WR;
            end else begin
              s_ack_o <= 1'b1;
              state   <= ACK;
            end
          end
        end

        RD: begin
          if (!s_cyc_i) abort <= 1'b1;
          if (inv_i) inv_seen <= 1'b1;
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_sel_o <= '0;
            // Any invalidate seen during the fetch leaves the filled word invalid.
            if ((CACHE_EN != 0) && !inv_seen && !inv_i) valid <= 1'b1;
            s_dat_o <= lane_of(m_dat_i, req_lane);
            if (abort || !s_cyc_i) begin
              state <= IDLE;
            end else begin
              s_ack_o <= 1'b1;
              state   <= ACK;
            end
          end
        end

        WR: begin
          if (!s_cyc_i) abort <= 1'b1;
          if (m_ack_i) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            if (abort || !s_cyc_i) begin
              state <= IDLE;
            end else begin
              s_ack_o <= 1'b1;
              state   <= ACK;
            end
          end
        end

        ACK: begin
          s_ack_o <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Buffer contents carry no reset; validity is tracked by the FSM block.
  always_ff @(posedge clk) begin
    if (reset_n && m_ack_i) begin
      if (state == RD) begin
        rbuf_tag  <= req_word;
        rbuf_data <= m_dat_i;
      end else if (state == WR && valid && rbuf_tag == req_word) begin
        rbuf_data <= merge_lane(rbuf_data, req_lane, req_dat);
      end
    end
  end

endmodule

// File: tb/tb_sp_wb8_responder.sv
// Randomized bench for sp_wb8_responder against a word-level memory and buffer model.
module tb_sp_wb8_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [0:23] s_adr_i;
  logic [0:7]  s_dat_i;
  logic [0:7]  s_dat_o;
  logic        s_we_i;
  logic [0:0]  s_sel_i;
  logic        s_stb_i;
  logic        s_cyc_i;
  logic        s_ack_o;
  logic [0:31] m_adr_o;
  logic [0:31] m_dat_o;
  logic [0:31] m_dat_i;
  logic        m_we_o;
  logic        m_stb_o;
  logic        m_cyc_o;
  logic [0:3]  m_sel_o;
  logic        m_ack_i;
  logic        inv_i;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [7:0] BASE = 8'h00;

  logic [31:0] mem [logic [21:0]];
  bit          c_valid;
  logic [21:0] c_tag;
  logic [31:0] c_word;

  sp_wb8_responder #(.BASE_ADR(BASE), .CACHE_EN(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
    .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i),
    .inv_i(inv_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [21:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] word, input int lane);
    return 8'((word >> (8 * (3 - lane))) & 32'hFF);
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input int lane,
                                           input logic [7:0] b);
    int sh;
    sh = 8 * (3 - lane);
    return (word & ~(32'hFF << sh)) | (32'(b) << sh);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_req();
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
  endtask

  task automatic do_read(input logic [23:0] adr, input int waits, input int inv_at, input bit drop);
    logic [21:0] w;
    int          l;
    bit          hit;
    logic [31:0] word;
    logic [7:0]  exp;
    logic [31:0] exp_adr;
    w       = 22'(adr >> 2);
    l       = int'(adr % 4);
    hit     = c_valid && (c_tag == w);
    word    = hit ? c_word : mem_word(w);
    exp     = byte_of(word, l);
    exp_adr = {BASE, 24'(adr & 24'hFFFFFC)};
    s_adr_i = adr; s_we_i = 1'b0; s_sel_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    tick();
    if (hit) begin
      n_cmp++;
      if ({s_ack_o, m_cyc_o} !== 2'b10) begin
        n_fail++; $display("FAIL rd_hit_ack adr=%h: ack,cyc=%b required 10", adr, {s_ack_o, m_cyc_o});
      end
      n_cmp++;
      if (s_dat_o !== exp) begin
        n_fail++; $display("FAIL rd_hit_data adr=%h: got %h required %h", adr, s_dat_o, exp);
      end
      drop_req();
      tick();
      n_cmp++;
      if ({s_ack_o, m_cyc_o} !== 2'b00) begin
        n_fail++; $display("FAIL rd_hit_ack_len adr=%h: ack,cyc=%b required 00", adr, {s_ack_o, m_cyc_o});
      end
      return;
    end
    n_cmp++;
    if ({s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o} !== 8'b0110_1111) begin
      n_fail++; $display("FAIL rd_start adr=%h: ack,cyc,stb,we,sel=%b required 01101111",
                         adr, {s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o});
    end
    n_cmp++;
    if (m_adr_o !== exp_adr || m_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL rd_adr adr=%h: m_adr=%h m_dat=%h required %h 0", adr, m_adr_o, m_dat_o, exp_adr);
    end
    for (int i = 0; i < waits; i++) begin
      if (i == inv_at) inv_i = 1'b1;
      if (drop && i == 0) begin drop_req(); s_adr_i = 24'($urandom); end
      m_dat_i = $urandom;
      tick();
      inv_i = 1'b0;
      n_cmp++;
      if ({m_cyc_o, s_ack_o} !== 2'b10 || m_adr_o !== exp_adr) begin
        n_fail++; $display("FAIL rd_wait adr=%h: cyc,ack=%b m_adr=%h required 10 %h",
                           adr, {m_cyc_o, s_ack_o}, m_adr_o, exp_adr);
      end
    end
    if (inv_at == waits) inv_i = 1'b1;
    if (drop && waits == 0) drop_req();
    m_ack_i = 1'b1; m_dat_i = word;
    tick();
    m_ack_i = 1'b0; inv_i = 1'b0; m_dat_i = $urandom;
    c_tag = w; c_word = word;
    c_valid = !(inv_at >= 0 && inv_at <= waits);
    n_cmp++;
    if ({m_cyc_o, m_stb_o} !== 2'b00) begin
      n_fail++; $display("FAIL rd_end adr=%h: cyc,stb=%b required 00", adr, {m_cyc_o, m_stb_o});
    end
    if (drop) begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (s_ack_o !== 1'b0) begin
          n_fail++; $display("FAIL rd_abort_ack adr=%h: s_ack=%b required 0", adr, s_ack_o);
        end
        tick();
      end
      return;
    end
    n_cmp++;
    if (s_ack_o !== 1'b1 || s_dat_o !== exp) begin
      n_fail++; $display("FAIL rd_miss_data adr=%h: ack=%b dat=%h required 1 %h", adr, s_ack_o, s_dat_o, exp);
    end
    drop_req();
    tick();
    n_cmp++;
    if (s_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_miss_ack_len adr=%h: s_ack=%b required 0", adr, s_ack_o);
    end
  endtask

  task automatic do_write(input logic [23:0] adr, input logic [7:0] dat, input bit sel,
                          input int waits, input bit drop);
    logic [21:0] w;
    int          l;
    logic [3:0]  exp_sel;
    logic [31:0] exp_adr;
    w       = 22'(adr >> 2);
    l       = int'(adr % 4);
    exp_sel = 4'b1000 >> l;
    exp_adr = {BASE, 24'(adr & 24'hFFFFFC)};
    s_adr_i = adr; s_dat_i = dat; s_we_i = 1'b1; s_sel_i = sel; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    tick();
    if (!sel) begin
      n_cmp++;
      if ({s_ack_o, m_cyc_o} !== 2'b10) begin
        n_fail++; $display("FAIL wr_nosel adr=%h: ack,cyc=%b required 10", adr, {s_ack_o, m_cyc_o});
      end
      drop_req();
      tick();
      n_cmp++;
      if ({s_ack_o, m_cyc_o} !== 2'b00) begin
        n_fail++; $display("FAIL wr_nosel_len adr=%h: ack,cyc=%b required 00", adr, {s_ack_o, m_cyc_o});
      end
      return;
    end
    n_cmp++;
    if ({s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o} !== {4'b0111, exp_sel}) begin
      n_fail++; $display("FAIL wr_start adr=%h: ack,cyc,stb,we,sel=%b required %b",
                         adr, {s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}, {4'b0111, exp_sel});
    end
    n_cmp++;
    if (m_dat_o !== {4{dat}} || m_adr_o !== exp_adr) begin
      n_fail++; $display("FAIL wr_data adr=%h: m_dat=%h m_adr=%h required %h %h",
                         adr, m_dat_o, m_adr_o, {4{dat}}, exp_adr);
    end
    for (int i = 0; i < waits; i++) begin
      if (drop && i == 0) begin drop_req(); s_adr_i = 24'($urandom); s_dat_i = 8'($urandom); end
      tick();
      n_cmp++;
      if ({m_cyc_o, m_we_o, s_ack_o} !== 3'b110 || m_adr_o !== exp_adr) begin
        n_fail++; $display("FAIL wr_wait adr=%h: cyc,we,ack=%b m_adr=%h required 110 %h",
                           adr, {m_cyc_o, m_we_o, s_ack_o}, m_adr_o, exp_adr);
      end
    end
    if (drop && waits == 0) drop_req();
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    mem[w] = put_byte(mem_word(w), l, dat);
    if (c_valid && c_tag == w) c_word = put_byte(c_word, l, dat);
    n_cmp++;
    if ({m_cyc_o, m_stb_o, s_ack_o} !== {2'b00, !drop}) begin
      n_fail++; $display("FAIL wr_end adr=%h: cyc,stb,ack=%b required %b",
                         adr, {m_cyc_o, m_stb_o, s_ack_o}, {2'b00, !drop});
    end
    drop_req();
    tick();
    n_cmp++;
    if (s_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_ack_len adr=%h: s_ack=%b required 0", adr, s_ack_o);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_adr_i = '0; s_dat_i = '0; s_we_i = 1'b0; s_sel_i = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
    m_dat_i = '0; m_ack_i = 1'b0; inv_i = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o} !== 8'h00 || m_dat_o !== 32'h0 || s_dat_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_state: ctl=%b m_dat=%h s_dat=%h required 0 0 0",
                         {s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}, m_dat_o, s_dat_o);
    end
    reset_n = 1'b1;
    c_valid = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    mem[22'h40] = 32'h11223344;
    do_read(24'h000102, 3, -1, 1'b0);
    do_read(24'h000103, 0, -1, 1'b0);
    do_write(24'h000101, 8'hAB, 1'b1, 2, 1'b0);
    do_read(24'h000101, 0, -1, 1'b0);
  endtask

  task automatic test_no_sel_write();
    do_write(24'h000102, 8'h5A, 1'b0, 0, 1'b0);
    do_read(24'h000102, 0, -1, 1'b0);
  endtask

  task automatic test_invalidate();
    do_read(24'h000200, 2, 1, 1'b0);
    do_read(24'h000201, 1, -1, 1'b0);
    do_read(24'h000300, 2, 2, 1'b0);
    do_read(24'h000302, 0, -1, 1'b0);
  endtask

  task automatic test_abort();
    do_read(24'h000400, 2, -1, 1'b1);
    do_read(24'h000403, 0, -1, 1'b0);
    do_write(24'h000402, 8'hC3, 1'b1, 1, 1'b1);
    do_read(24'h000402, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_wr();
    do_read(24'h000100, 0, -1, 1'b0);
    s_adr_i = 24'h000105; s_dat_i = 8'h77; s_we_i = 1'b1; s_sel_i = 1'b1;
    s_cyc_i = 1'b1; s_stb_i = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    drop_req();
    tick();
    reset_n = 1'b1;
    c_valid = 1'b0;
    n_cmp++;
    if ({m_cyc_o, m_stb_o, s_ack_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_wr: cyc,stb,ack=%b required 000", {m_cyc_o, m_stb_o, s_ack_o});
    end
    for (int i = 0; i < 3; i++) begin
      m_ack_i = (i == 0);
      tick();
      m_ack_i = 1'b0;
      n_cmp++;
      if (s_ack_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_wr_ack: s_ack=%b required 0", s_ack_o);
      end
    end
    do_read(24'h000100, 1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    do_read(24'h000500, 0, -1, 1'b0);
    exp = byte_of(c_word, 1);
    s_adr_i = 24'h000501; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) drop_req();
      tick();
      n_cmp++;
      if (s_ack_o !== (i % 2 == 0) || m_cyc_o !== 1'b0) begin
        n_fail++; $display("FAIL back_to_back cycle %0d: ack=%b cyc=%b required %b 0",
                           i, s_ack_o, m_cyc_o, (i % 2 == 0));
      end
      if (s_ack_o === 1'b1 && s_dat_o !== exp) begin
        n_cmp++; n_fail++;
        $display("FAIL back_to_back_data: got %h required %h", s_dat_o, exp);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [21:0] words [4];
    logic [23:0] adr;
    int          waits;
    int          inv_at;
    words[0] = 22'h000040; words[1] = 22'h000041; words[2] = 22'h000080; words[3] = 22'h3FFFFF;
    for (int n = 0; n < 80; n++) begin
      adr    = {words[$urandom_range(3)], 2'($urandom_range(3))};
      waits  = $urandom_range(3);
      inv_at = ($urandom_range(5) == 0) ? $urandom_range(waits) : -1;
      if ($urandom_range(1) == 0)
        do_read(adr, waits, inv_at, $urandom_range(7) == 0);
      else
        do_write(adr, 8'($urandom), $urandom_range(3) != 0, waits, $urandom_range(7) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_no_sel_write();
    test_invalidate();
    test_abort();
    test_reset_mid_wr();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
